serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder sequencer: adds two WIDTH-bit operands plus carry-in by driving
//  a single full_adder instance, one bit per clock, LSB first. Trades WIDTH cycles
//  of latency for one adder cell. Sits between a requester (start/done handshake)
//  and the shared full_adder datapath. Owns operand shift registers, carry flop, bit counter, FSM.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 1..64
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A; captured on the accepted start edge
//  b      in   WIDTH  operand B; captured on the accepted start edge
//  c_in   in   1      carry-in; captured on the accepted start edge
//  busy   out  1      high in RUN and DONE; start is ignored while high
//  done   out  1      one-cycle pulse; sum/c_out valid in this cycle
//  sum    out  WIDTH  registered result; holds until the next completion
//  c_out  out  1      registered carry-out of the MSB; holds like sum
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; busy=0; done=0; sum=0; c_out=0.
//   Shift registers, carry flop and bit counter clear to 0. Takes effect
//   mid-operation: the pending add is abandoned; no done pulse is generated.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 at edge k -> load a_sh<=a, b_sh<=b, cy<=c_in, cnt<=0, go to RUN.
//   RUN:  each edge: full_adder(x=a_sh[0], y=b_sh[0], c_in=cy).
//         cy<=FA.c_out; s_sh<={FA.s, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; cnt<=cnt+1.
//         At the edge where cnt==WIDTH-1: sum<=final s_sh, c_out<=FA.c_out, go to DONE.
//   DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
//  Latency: start accepted at edge k -> done=1 in cycle after edge k+WIDTH.
//   Throughput: one add per WIDTH+2 cycles (IDLE, RUN x WIDTH, DONE).
//  busy=1 in RUN and DONE (combinational from state); done=1 only in DONE.
//  start while busy=1 (incl. DONE cycle) is ignored, not queued; a/b/c_in are don't-care there.
//  sum/c_out change only on the RUN->DONE edge; stable at all other times.
//  Result = (a + b + c_in) mod 2^WIDTH; c_out = bit WIDTH of the full sum.
//  cnt width = $clog2(WIDTH+1); WIDTH=1 must work: one RUN cycle, then DONE.
//  The datapath is the existing full_adder cell, instantiated exactly once.
//   Do not add a behavioural '+'.
// TESTING
//  T1 WIDTH=8: a=0x5A, b=0x3C, c_in=0, start pulse -> done 9 cycles after the
//     start edge; sum=0x96, c_out=0; busy high exactly 9 cycles.
//  T2 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1.
//     a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1.
//  T3 start held high continuously with a=0x10, b=0x20 -> new add accepted in every
//     IDLE cycle; results 0x30 each; no acceptance while busy; sum stable between dones.
//  T4 rst asserted asynchronously in RUN at cnt=4 -> busy=0, sum=0, c_out=0 immediately.
//     No done pulse. A fresh a=0x01, b=0x01 start after release -> sum=0x02.
//  T5 WIDTH=1: a=1, b=1, c_in=1 -> done 2 cycles after the start edge; sum=1, c_out=1.
//  T6 Random: 1000 operand sets at WIDTH=8 and WIDTH=13, checked against the
//     reference model {c_out,sum} = a+b+c_in.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. A single full_adder cell is reused once per bit,
// LSB first, so a WIDTH-bit add takes WIDTH RUN cycles plus one DONE cycle.
// The requester side uses a start/done handshake, and busy covers RUN and DONE.

// One-bit full adder cell: the only arithmetic in the datapath.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  // The shared adder cell always looks at the current LSBs and the carry flop.
  full_adder u_fa (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .c_in  (cy),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // New sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_s_one
      assign s_next = fa_s;
    end else begin : g_s_wide
      assign s_next = {fa_s, s_sh[WIDTH-1:1]};
    end
  endgenerate

  // Status flags are decoded straight from the state register.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Sequencer: capture operands, step one bit per clock, publish the result once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            cy    <= c_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          cy   <= fa_co;
          s_sh <= s_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            sum   <= s_next;
            c_out <= fa_co;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
